counter_gen: RTL
================

# counter_gen

Parametrised successor to the team's 4-bit mode counter: a WIDTH-bit synchronous up/down/load counter with programmable up-step, selectable wrap or saturate behaviour, a registered ripple-carry-out (rco) event and a saturating rollover tally. It is the counter instance under test in the timing-design scoreboard flow. It is built twice, as behavioural RTL and as the synthesised cmos-cell netlist, and the two are compared cycle by cycle.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥2)
- STEP, 3, increment applied in mode 00 (1 ≤ STEP ≤ 2^WIDTH−1)
- CNT_W, 8, width of the rollover tally

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- enable  in  1  count/load qualifier
- mode  in  2  00 up by STEP, 01 down by 1, 10 up by 1, 11 load D
- sat  in  1  0 = wrap modulo 2^WIDTH, 1 = clamp at all-ones/zero
- D  in  WIDTH  parallel load value
- clr_tally  in  1  synchronous clear of the tally
- Q  out  WIDTH  counter value
- rco  out  1  one-cycle pulse on overflow/underflow event
- load  out  1  one-cycle pulse confirming a load
- tally  out  CNT_W  number of rco events since reset/clear, saturating

## Operation
- Reset (reset=0, asynchronous): Q=0, rco=0, load=0, tally=0. This holds for as long as reset is low. The first update occurs on the first rising clk edge after reset deasserts.
- enable=0: Q holds. rco=0, load=0. tally holds unless clr_tally=1.
- enable=1, mode 00: compute Q+STEP in WIDTH+1 bits; carry set → overflow event.
- enable=1, mode 10: the same with step 1.
- enable=1, mode 01: Q−1; Q==0 → underflow event.
- Wrap mode (sat=0): Q takes the low WIDTH bits of the result. For example, WIDTH=4: 14+3 → 1, and 0−1 → 15.
- Saturate mode (sat=1): on an overflow event Q=2^WIDTH−1; on an underflow event Q=0. rco still pulses on every cycle the clamp is applied, so a counter held at a limit pulses rco each enabled cycle.
- Mode 11: Q=D, load=1 for that cycle. A load never raises rco, even when D is all-ones or zero.
- tally increments by 1 on each cycle rco is set, and stops at 2^CNT_W−1.
- clr_tally=1 forces tally=0 on the next edge, and takes priority over a simultaneous increment.
- mode and sat are sampled every edge. Changes mid-count take effect on the next edge with no pipeline flush.

## Timing
- All outputs are registered, with latency 1 cycle from sampled inputs to Q/rco/load/tally.
- rco and load are high for exactly one cycle per event and are never both high.
- No combinational path from inputs to outputs, so the synthesised netlist is cycle-equivalent to the RTL.
- Asynchronous assertion of reset mid-count clears outputs within the same cycle. Deassertion is synchronised externally by the bench or system.

## Structure
- Package counter_gen_pkg holds:
  - mode encodings (MODE_UP_STEP=2'b00, MODE_DOWN=2'b01, MODE_UP1=2'b10, MODE_LOAD=2'b11)
  - default parameter constants
- Sub-module counter_gen_next: a combinational next-state/event calculator.
  - Inputs: Q, mode, sat, D, enable.
  - Outputs: q_next, ev_rco, ev_load.
  - The top module holds only the registers and the tally.
- Both RTL and synthesised versions expose an identical port list for the scoreboard.

## Test plan
- Reset then idle: hold reset=0 for 2 cycles with enable=1, mode=00 → Q=0, rco=0, load=0, tally=0 throughout. After release, Q sequence is 3, 6, 9, 12, 15, 2 with rco=1 only on the 15→2 edge, and tally=1.
- Down wrap: load D=1 (load=1 one cycle), then mode 01 → Q 0, 15 with rco=1 on the 0→15 edge. The load cycle has rco=0.
- Saturate: sat=1, mode 10 from Q=14 → Q 15, 15, 15 with rco on the second and third edges. Mode 01 from 0 → Q stays 0 with rco every cycle.
- Enable gating and mode switch: enable toggled 1,0,1 in mode 10 from Q=5 → Q 6, 6, 7. Switching to mode 11 with D=9 mid-run gives Q=9 next edge with load=1.
- Tally saturation and clear: CNT_W=2 with forced repeated overflows → tally 1, 2, 3, 3. clr_tally asserted together with an overflow → tally=0.
- Asynchronous reset mid-count: drop reset between clock edges at Q=7 → Q=0 before the next edge. RTL and netlist Q/rco/load compare equal over 100 random iterations.

Source files
------------

// File: rtl/counter_gen_pkg.sv
// Shared mode encodings and default parameters for the counter_gen block.
package counter_gen_pkg;

  typedef enum logic [1:0] {
    MODE_UP_STEP = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_UP1     = 2'b10,
    MODE_LOAD    = 2'b11
  } mode_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_STEP  = 3;
  localparam int DEF_CNT_W = 8;

endpackage : counter_gen_pkg

// File: rtl/counter_gen_next.sv
// Combinational next-value and event calculator for counter_gen.
// Holds no state; the top registers everything it produces.
module counter_gen_next
  import counter_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic [WIDTH-1:0] Q,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] D,
  input  logic             enable,
  output logic [WIDTH-1:0] q_next,
  output logic             ev_rco,
  output logic             ev_load
);

  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic [WIDTH:0] sum_step;
  logic [WIDTH:0] sum_one;

  // Up sums are formed one bit wider so the carry marks an overflow.
  always_comb begin
    sum_step = {1'b0, Q} + STEP_EXT;
    sum_one  = {1'b0, Q} + ONE_EXT;
  end

  // Select the next value and raise the event flags; disabled means hold.
  always_comb begin
    q_next  = Q;
    ev_rco  = 1'b0;
    ev_load = 1'b0;
    if (enable) begin
      case (mode_e'(mode))
        MODE_UP_STEP: begin
          ev_rco = sum_step[WIDTH];
          q_next = (sat && sum_step[WIDTH]) ? ALL_ONES : sum_step[WIDTH-1:0];
        end
        MODE_UP1: begin
          ev_rco = sum_one[WIDTH];
          q_next = (sat && sum_one[WIDTH]) ? ALL_ONES : sum_one[WIDTH-1:0];
        end
        MODE_DOWN: begin
          ev_rco = (Q == ZERO);
          q_next = (sat && (Q == ZERO)) ? ZERO : (Q - 1'b1);
        end
        MODE_LOAD: begin
          // A load is never an overflow, whatever D holds.
          q_next  = D;
          ev_load = 1'b1;
        end
        default: begin
          q_next = Q;
        end
      endcase
    end
  end

endmodule : counter_gen_next

// File: rtl/counter_gen.sv
// WIDTH-bit up/down/load counter with wrap or saturate, registered
// rco/load pulses and a saturating rollover tally. All outputs are flops.
module counter_gen
  import counter_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] D,
  input  logic             clr_tally,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load,
  output logic [CNT_W-1:0] tally
);

  localparam logic [CNT_W-1:0] TALLY_MAX = '1;

  logic [WIDTH-1:0] q_next;
  logic             ev_rco;
  logic             ev_load;

  counter_gen_next #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_next (
    .Q       (Q),
    .mode    (mode),
    .sat     (sat),
    .D       (D),
    .enable  (enable),
    .q_next  (q_next),
    .ev_rco  (ev_rco),
    .ev_load (ev_load)
  );

  // Counter value and one-cycle event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q    <= '0;
      rco  <= 1'b0;
      load <= 1'b0;
    end else begin
      Q    <= q_next;
      rco  <= ev_rco;
      load <= ev_load;
    end
  end

  // Rollover tally: clear wins over a same-cycle increment; sticks at max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tally <= '0;
    end else if (clr_tally) begin
      tally <= '0;
    end else if (ev_rco && (tally != TALLY_MAX)) begin
      tally <= tally + 1'b1;
    end
  end

endmodule : counter_gen
